// File: rtl/apb4_mst_pkg.sv
// Shared types for the APB4 master bridge: FSM state encoding, latched
// request control fields and the pprot reset value.
package apb4_mst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb4_mst_state_e;

    // Width-independent part of a request; address/data/strobe widths follow
    // the bridge parameters and are held alongside this struct.
    typedef struct packed {
        logic       write;
        logic [2:0] prot;
    } apb4_mst_ctrl_t;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb4_master_bridge.sv
// Valid/ready request port to single APB4 initiator transfers, one outstanding.
// Optional access timeout enabled by defining APB4_MST_TIMEOUT_EN.
module apb4_master_bridge
    import apb4_mst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TMO_WIDTH  = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_tmo_o,
    input  logic [TMO_WIDTH-1:0]    tmo_lmt_i,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    apb4_mst_state_e         state_q,     state_d;
    apb4_mst_ctrl_t          ctrl_q,      ctrl_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q,      strb_d;
    logic                    psel_q,      psel_d;
    logic                    penable_q,   penable_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q,   rsp_err_d;

`ifdef APB4_MST_TIMEOUT_EN
    logic                    rsp_tmo_q,   rsp_tmo_d;
    logic [TMO_WIDTH-1:0]    cnt_q,       cnt_d;
    logic [TMO_WIDTH-1:0]    cnt_inc;
    logic                    tmo_hit;

    // cnt_q counts earlier stalled ACCESS cycles, so cnt_inc includes this one.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TMO_WIDTH'(1);
    assign tmo_hit = (tmo_lmt_i != '0) && (cnt_inc >= tmo_lmt_i) && !pready;
`else
    logic unused_tmo_lmt;
    assign unused_tmo_lmt = ^tmo_lmt_i;
`endif

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB4_MST_TIMEOUT_EN
        rsp_tmo_d   = rsp_tmo_q;
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    ctrl_d.write = req_write_i;
                    ctrl_d.prot  = req_prot_i;
                    addr_d       = req_addr_i;
                    wdata_d      = req_wdata_i;
                    strb_d       = req_write_i ? req_strb_i : '0;
                    psel_d       = 1'b1;
                    req_ready_d  = 1'b0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
`ifdef APB4_MST_TIMEOUT_EN
                cnt_d     = '0;
`endif
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (ctrl_q.write || pslverr) ? '0 : prdata;
                    rsp_err_d   = pslverr;
`ifdef APB4_MST_TIMEOUT_EN
                    rsp_tmo_d   = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef APB4_MST_TIMEOUT_EN
                else if (tmo_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= IDLE;
            ctrl_q      <= '{write: 1'b0, prot: PPROT_DEFAULT};
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
            rsp_tmo_q   <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB4_MST_TIMEOUT_EN
            rsp_tmo_q   <= rsp_tmo_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
`ifdef APB4_MST_TIMEOUT_EN
    assign rsp_tmo_o   = rsp_tmo_q;
`else
    assign rsp_tmo_o   = 1'b0;
`endif
    assign paddr       = addr_q;
    assign pprot       = ctrl_q.prot;
    assign pwrite      = ctrl_q.write;
    assign pwdata      = wdata_q;
    assign pstrb       = strb_q;
    assign psel        = psel_q;
    assign penable     = penable_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: vector table plus directed
// sequences for reset-in-flight and (with APB4_MST_TIMEOUT_EN) timeouts.
module tb_apb4_master_bridge;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_strb_i;
    logic [2:0]  req_prot_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o, rsp_tmo_o;
    logic [15:0] tmo_lmt_i;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;

    apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TMO_WIDTH(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
        .req_prot_i(req_prot_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o), .tmo_lmt_i(tmo_lmt_i),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        int          hold;
        logic [31:0] prd;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
                                logic [2:0] p, int wt, int hd, logic [31:0] prd, logic se,
                                logic [31:0] er, logic ee);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.prot = p;
        v.waits = wt; v.hold = hd; v.prd = prd; v.slverr = se;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Scoreboard: compare every consumed response against the oldest expectation.
    always @(negedge pclk) begin
        if (presetn && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", 1, 0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err",   rsp_err_o,   e.err);
                chk("rsp_tmo",   rsp_tmo_o,   e.tmo);
            end
        end
    end

    task automatic send_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s, input logic [2:0] p);
        req_write_i = w; req_addr_i = a; req_wdata_i = wd; req_strb_i = s; req_prot_i = p;
        req_valid_i = 1'b1;
        chk("idle_req_ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        chk("setup_psel",    psel,    1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr",   paddr,   a);
        chk("setup_pwrite",  pwrite,  w);
        chk("setup_pstrb",   pstrb,   w ? s : 4'h0);
        chk("setup_pprot",   pprot,   p);
        if (w) chk("setup_pwdata", pwdata, wd);
    endtask

    task automatic finish_rsp();
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("post_rsp_valid",     rsp_valid_o, 0);
        chk("post_rsp_req_ready", req_ready_o, 1);
        chk("post_rsp_psel",      psel,        0);
    endtask

    task automatic run_vec(input vec_t v);
        rsp_t e;
        send_req(v.write, v.addr, v.wdata, v.strb, v.prot);
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.tmo = 1'b0;
        exp_q.push_back(e);
        tick();
        for (int w = 0; w <= v.waits; w++) begin
            chk("access_psel",    psel,    1);
            chk("access_penable", penable, 1);
            chk("access_paddr",   paddr,   v.addr);
            chk("access_pstrb",   pstrb,   v.write ? v.strb : 4'h0);
            // A competing request must not be taken while a transfer is open.
            req_valid_i = 1'b1; req_addr_i = 32'hDEAD_BEE0;
            chk("busy_req_ready", req_ready_o, 0);
            pready  = (w == v.waits);
            prdata  = (w == v.waits) ? v.prd : 32'hBAD0_0000;
            pslverr = (w == v.waits) ? v.slverr : 1'b0;
            tick();
        end
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hBAD0_0001;
        chk("resp_psel",      psel,        0);
        chk("resp_penable",   penable,     0);
        chk("resp_valid",     rsp_valid_o, 1);
        chk("resp_req_ready", req_ready_o, 0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_rsp_valid", rsp_valid_o, 1);
            chk("hold_rsp_rdata", rsp_rdata_o, v.exp_rdata);
            chk("hold_psel",      psel,        0);
        end
        finish_rsp();
    endtask

    initial begin
        presetn = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
        req_wdata_i = '0; req_strb_i = '0; req_prot_i = '0; rsp_ready_i = 1'b0;
        tmo_lmt_i = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;

        vecs.push_back(mk(1'b1, 32'h10, 32'h1234_5678, 4'hF, 3'b000, 0,  0, 32'h0,         1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h08, 32'h0,         4'hF, 3'b000, 3,  1, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0));
        vecs.push_back(mk(1'b0, 32'h20, 32'h0,         4'h0, 3'b010, 0,  5, 32'hDEAD_0000, 1'b1, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 32'h44, 32'hCAFE_F00D, 4'h3, 3'b101, 1,  0, 32'h0,         1'b1, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 32'hFFFF_FFFC, 32'h0,  4'h5, 3'b111, 0,  2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h100, 32'h0000_00FF, 4'h1, 3'b001, 2, 0, 32'h5555_5555, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h204, 32'h0,         4'h0, 3'b000, 12, 0, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 1'b0));

        repeat (3) tick();
        presetn = 1'b1;
        chk("rst_psel",      psel,        0);
        chk("rst_penable",   penable,     0);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_err",   rsp_err_o,   0);
        chk("rst_rsp_tmo",   rsp_tmo_o,   0);
        chk("rst_paddr",     paddr,       0);
        chk("rst_pstrb",     pstrb,       0);
        chk("rst_pwrite",    pwrite,      0);
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while stalled in ACCESS: response dropped, next transfer normal.
        send_req(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
        tick();
        chk("pre_rst_penable", penable, 1);
        tick();
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        chk("midrst_psel",      psel,        0);
        chk("midrst_penable",   penable,     0);
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        chk("midrst_req_ready", req_ready_o, 1);
        tick();
        run_vec(vecs[0]);

`ifdef APB4_MST_TIMEOUT_EN
        begin
            rsp_t e;
            int   acc;
            tmo_lmt_i = 16'd4;
            send_req(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
            e.rdata = 32'h0; e.err = 1'b1; e.tmo = 1'b1;
            exp_q.push_back(e);
            tick();
            acc = 0;
            for (int c = 0; c < 20; c++) begin
                if (!(psel && penable)) break;
                acc++;
                tick();
            end
            chk("tmo_access_cycles", acc, 4);
            chk("tmo_rsp_valid", rsp_valid_o, 1);
            chk("tmo_psel",      psel,        0);
            finish_rsp();

            // pready in the limit cycle completes normally.
            tmo_lmt_i = 16'd2;
            run_vec(mk(1'b0, 32'h54, 32'h0, 4'h0, 3'b000, 1, 0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0));
            tmo_lmt_i = 16'd0;
            run_vec(mk(1'b1, 32'h58, 32'h2468_ACE0, 4'hC, 3'b000, 15, 0, 32'h0, 1'b0, 32'h0, 1'b0));
        end
`endif

        tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
